// File: rtl/core_ex_trap_pkg.sv
// Shared cause codes, mstatus field positions and FSM/action encodings
// for the EX-stage trap unit.
package core_ex_trap_pkg;

   localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
   localparam logic [3:0] EXC_EBREAK      = 4'd3;
   localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
   localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
   localparam logic [3:0] EXC_ECALL       = 4'd11;

   localparam logic [3:0] IRQ_SW    = 4'd3;
   localparam logic [3:0] IRQ_TIMER = 4'd7;
   localparam logic [3:0] IRQ_EXT   = 4'd11;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } trap_state_e;

   typedef enum logic [1:0] {
      ACT_NONE = 2'd0,
      ACT_TRAP = 2'd1,
      ACT_MRET = 2'd2
   } trap_act_e;

endpackage

// File: rtl/core_irq_sync.sv
// N-flop synchroniser for an asynchronous level input; reset clears every stage.
module core_irq_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/core_ex_trap.sv
// EX-stage exception/interrupt/MRET arbiter: registered CSR commit writes and a
// held flush/redirect request toward pipeline control.
module core_ex_trap
   import core_ex_trap_pkg::*;
#(
   parameter int unsigned XLEN            = 32,
   parameter int unsigned PC_WIDTH        = 32,
   parameter int unsigned IRQ_SYNC_STAGES = 2,
   parameter int unsigned VECTORED_EN     = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ex_valid,
   input  logic [PC_WIDTH-1:0] ex_pc,
   input  logic                excp_illegal,
   input  logic                excp_ecall,
   input  logic                excp_ebreak,
   input  logic                excp_ld_misalign,
   input  logic                excp_st_misalign,
   input  logic                excp_mret,
   input  logic [XLEN-1:0]     ex_badaddr,
   input  logic                irq_sw,
   input  logic                irq_timer,
   input  logic                irq_ext,
   input  logic [XLEN-1:0]     csr_mstatus,
   input  logic [XLEN-1:0]     csr_mie,
   input  logic [XLEN-1:0]     csr_mtvec,
   input  logic [XLEN-1:0]     csr_mepc,
   output logic                cmt_mstatus_en,
   output logic                cmt_mcause_en,
   output logic                cmt_mepc_en,
   output logic                cmt_mtval_en,
   output logic [XLEN-1:0]     cmt_mstatus,
   output logic [XLEN-1:0]     cmt_mcause,
   output logic [XLEN-1:0]     cmt_mepc,
   output logic [XLEN-1:0]     cmt_mtval,
   output logic                flush_req,
   output logic [PC_WIDTH-1:0] flush_pc,
   input  logic                flush_ack,
   output logic                trap_busy
);

   trap_state_e         state_q, state_d;
   trap_act_e           act;
   logic                irq_ext_s;
   logic                is_irq;
   logic                is_misalign;
   logic [3:0]          cause;
   logic [XLEN-1:0]     mcause_d;
   logic [XLEN-1:0]     mstatus_trap;
   logic [XLEN-1:0]     mstatus_mret;
   logic [XLEN-1:0]     tvec_base;
   logic [XLEN-1:0]     trap_target;
   logic [PC_WIDTH-1:0] flush_pc_q;
   logic                unused_mie;

   core_irq_sync #(
      .STAGES (IRQ_SYNC_STAGES)
   ) u_irq_ext_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq_ext),
      .q     (irq_ext_s)
   );

   assign unused_mie = ^csr_mie;

   // Arbitration: interrupts > exceptions > MRET, only while idle.
   always_comb begin
      act         = ACT_NONE;
      is_irq      = 1'b0;
      is_misalign = 1'b0;
      cause       = '0;
      if (state_q == ST_IDLE && ex_valid) begin
         if (csr_mstatus[MSTATUS_MIE] && irq_ext_s && csr_mie[IRQ_EXT]) begin
            act = ACT_TRAP; is_irq = 1'b1; cause = IRQ_EXT;
         end else if (csr_mstatus[MSTATUS_MIE] && irq_sw && csr_mie[IRQ_SW]) begin
            act = ACT_TRAP; is_irq = 1'b1; cause = IRQ_SW;
         end else if (csr_mstatus[MSTATUS_MIE] && irq_timer && csr_mie[IRQ_TIMER]) begin
            act = ACT_TRAP; is_irq = 1'b1; cause = IRQ_TIMER;
         end else if (excp_illegal) begin
            act = ACT_TRAP; cause = EXC_ILLEGAL;
         end else if (excp_ecall) begin
            act = ACT_TRAP; cause = EXC_ECALL;
         end else if (excp_ebreak) begin
            act = ACT_TRAP; cause = EXC_EBREAK;
         end else if (excp_ld_misalign) begin
            act = ACT_TRAP; cause = EXC_LD_MISALIGN; is_misalign = 1'b1;
         end else if (excp_st_misalign) begin
            act = ACT_TRAP; cause = EXC_ST_MISALIGN; is_misalign = 1'b1;
         end else if (excp_mret) begin
            act = ACT_MRET;
         end
      end
   end

   always_comb begin
      mcause_d           = XLEN'(cause);
      mcause_d[XLEN-1]   = is_irq;

      mstatus_trap                                = csr_mstatus;
      mstatus_trap[MSTATUS_MPIE]                  = csr_mstatus[MSTATUS_MIE];
      mstatus_trap[MSTATUS_MIE]                   = 1'b0;
      mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      mstatus_mret                                = csr_mstatus;
      mstatus_mret[MSTATUS_MIE]                   = csr_mstatus[MSTATUS_MPIE];
      mstatus_mret[MSTATUS_MPIE]                  = 1'b1;
      mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      tvec_base   = {csr_mtvec[XLEN-1:2], 2'b00};
      trap_target = tvec_base;
      if (VECTORED_EN != 0 && csr_mtvec[1:0] == 2'b01 && is_irq)
         trap_target = tvec_base + XLEN'({cause, 2'b00});
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (act != ACT_NONE) state_d = ST_FLUSH;
         ST_FLUSH: if (flush_ack)       state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Strobes are single-cycle; data and redirect target hold until the next event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmt_mstatus_en <= 1'b0;
         cmt_mcause_en  <= 1'b0;
         cmt_mepc_en    <= 1'b0;
         cmt_mtval_en   <= 1'b0;
         cmt_mstatus    <= '0;
         cmt_mcause     <= '0;
         cmt_mepc       <= '0;
         cmt_mtval      <= '0;
         flush_pc_q     <= '0;
      end else begin
         cmt_mstatus_en <= 1'b0;
         cmt_mcause_en  <= 1'b0;
         cmt_mepc_en    <= 1'b0;
         cmt_mtval_en   <= 1'b0;
         if (act == ACT_TRAP) begin
            cmt_mstatus_en <= 1'b1;
            cmt_mcause_en  <= 1'b1;
            cmt_mepc_en    <= 1'b1;
            cmt_mtval_en   <= 1'b1;
            cmt_mstatus    <= mstatus_trap;
            cmt_mcause     <= mcause_d;
            cmt_mepc       <= XLEN'(ex_pc);
            cmt_mtval      <= is_misalign ? ex_badaddr : '0;
            flush_pc_q     <= PC_WIDTH'(trap_target);
         end else if (act == ACT_MRET) begin
            cmt_mstatus_en <= 1'b1;
            cmt_mstatus    <= mstatus_mret;
            flush_pc_q     <= PC_WIDTH'(csr_mepc);
         end
      end
   end

   assign flush_req = (state_q == ST_FLUSH);
   assign flush_pc  = flush_pc_q;
   assign trap_busy = (state_q != ST_IDLE) || (act != ACT_NONE);

endmodule

// File: tb/tb_core_ex_trap.sv
// Self-checking bench for core_ex_trap: directed vector table, randomized
// transactions against a rule-level reference model, and multi-cycle sequences.
module tb_core_ex_trap;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned PCW   = 32;
   localparam int unsigned NSYNC = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ex_valid;
   logic [PCW-1:0]  ex_pc;
   logic            excp_illegal, excp_ecall, excp_ebreak, excp_ld_misalign, excp_st_misalign, excp_mret;
   logic [XLEN-1:0] ex_badaddr;
   logic            irq_sw, irq_timer, irq_ext;
   logic [XLEN-1:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
   logic            cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en, cmt_mtval_en;
   logic [XLEN-1:0] cmt_mstatus, cmt_mcause, cmt_mepc, cmt_mtval;
   logic            flush_req;
   logic [PCW-1:0]  flush_pc;
   logic            flush_ack;
   logic            trap_busy;

   always #5 clk = ~clk;

   core_ex_trap #(
      .XLEN            (XLEN),
      .PC_WIDTH        (PCW),
      .IRQ_SYNC_STAGES (NSYNC),
      .VECTORED_EN     (1)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .excp_illegal     (excp_illegal),
      .excp_ecall       (excp_ecall),
      .excp_ebreak      (excp_ebreak),
      .excp_ld_misalign (excp_ld_misalign),
      .excp_st_misalign (excp_st_misalign),
      .excp_mret        (excp_mret),
      .ex_badaddr       (ex_badaddr),
      .irq_sw           (irq_sw),
      .irq_timer        (irq_timer),
      .irq_ext          (irq_ext),
      .csr_mstatus      (csr_mstatus),
      .csr_mie          (csr_mie),
      .csr_mtvec        (csr_mtvec),
      .csr_mepc         (csr_mepc),
      .cmt_mstatus_en   (cmt_mstatus_en),
      .cmt_mcause_en    (cmt_mcause_en),
      .cmt_mepc_en      (cmt_mepc_en),
      .cmt_mtval_en     (cmt_mtval_en),
      .cmt_mstatus      (cmt_mstatus),
      .cmt_mcause       (cmt_mcause),
      .cmt_mepc         (cmt_mepc),
      .cmt_mtval        (cmt_mtval),
      .flush_req        (flush_req),
      .flush_pc         (flush_pc),
      .flush_ack        (flush_ack),
      .trap_busy        (trap_busy)
   );

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        il, ec, eb, lm, sm, mret;
      logic [31:0] bad;
      logic        sw, tm, ext;
      logic [31:0] mstatus, mie, mtvec, mepc;
   } stim_t;

   typedef struct {
      int          take;   // 0 none, 1 trap, 2 mret
      logic [31:0] mcause, mepc, mtval, mstatus, fpc;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   int unsigned errors = 0;
   int unsigned checks = 0;
   vec_t        tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference behaviour from the architectural rules.
   function automatic exp_t ref_model(input stim_t s);
      exp_t e;
      int   code;
      bit   irq;
      e.take = 0; e.mcause = 0; e.mepc = 0; e.mtval = 0; e.mstatus = 0; e.fpc = 0;
      code = -1;
      irq  = 0;
      if (s.v) begin
         if (s.mstatus[3]) begin
            if (s.ext && s.mie[11])     code = 11;
            else if (s.sw && s.mie[3])  code = 3;
            else if (s.tm && s.mie[7])  code = 7;
         end
         if (code >= 0)  irq = 1;
         else if (s.il)  code = 2;
         else if (s.ec)  code = 11;
         else if (s.eb)  code = 3;
         else if (s.lm)  code = 4;
         else if (s.sm)  code = 6;
         if (code >= 0) begin
            e.take    = 1;
            e.mcause  = irq ? (32'h8000_0000 | 32'(code)) : 32'(code);
            e.mepc    = s.pc;
            e.mtval   = (!irq && (code == 4 || code == 6)) ? s.bad : 32'h0;
            e.mstatus = (s.mstatus & ~32'h1888) | 32'h1800 | (s.mstatus[3] ? 32'h80 : 32'h0);
            e.fpc     = (s.mtvec & ~32'h3) + ((irq && s.mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'h0);
         end else if (s.mret) begin
            e.take    = 2;
            e.mstatus = (s.mstatus & ~32'h1888) | 32'h1880 | (s.mstatus[7] ? 32'h8 : 32'h0);
            e.fpc     = s.mepc;
         end
      end
      return e;
   endfunction

   task automatic drive(input stim_t s);
      ex_valid = s.v; ex_pc = s.pc;
      excp_illegal = s.il; excp_ecall = s.ec; excp_ebreak = s.eb;
      excp_ld_misalign = s.lm; excp_st_misalign = s.sm; excp_mret = s.mret;
      ex_badaddr = s.bad; irq_sw = s.sw; irq_timer = s.tm; irq_ext = s.ext;
      csr_mstatus = s.mstatus; csr_mie = s.mie; csr_mtvec = s.mtvec; csr_mepc = s.mepc;
   endtask

   task automatic clear_ex();
      ex_valid = 0; excp_illegal = 0; excp_ecall = 0; excp_ebreak = 0;
      excp_ld_misalign = 0; excp_st_misalign = 0; excp_mret = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction from IDLE: settle irq_ext, present, check commit, ack after ack_dly cycles.
   task automatic apply(input stim_t s, input exp_t e, input string tag, input int ack_dly);
      clear_ex();
      irq_ext = s.ext;
      repeat (NSYNC + 1) tick();
      drive(s);
      #1;
      chk({tag, " busy_detect"}, trap_busy, e.take != 0);
      tick();
      clear_ex();
      chk({tag, " mstatus_en"}, cmt_mstatus_en, e.take != 0);
      chk({tag, " mcause_en"}, cmt_mcause_en, e.take == 1);
      chk({tag, " mepc_en"}, cmt_mepc_en, e.take == 1);
      chk({tag, " mtval_en"}, cmt_mtval_en, e.take == 1);
      chk({tag, " flush_req"}, flush_req, e.take != 0);
      chk({tag, " busy"}, trap_busy, e.take != 0);
      if (e.take == 1) begin
         chk({tag, " mcause"}, cmt_mcause, e.mcause);
         chk({tag, " mepc"}, cmt_mepc, e.mepc);
         chk({tag, " mtval"}, cmt_mtval, e.mtval);
      end
      if (e.take != 0) begin
         chk({tag, " mstatus"}, cmt_mstatus, e.mstatus);
         chk({tag, " flush_pc"}, flush_pc, e.fpc);
         for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk({tag, " hold_req"}, flush_req, 1);
            chk({tag, " hold_pc"}, flush_pc, e.fpc);
            chk({tag, " hold_no_strobe"}, {cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en, cmt_mtval_en}, 0);
         end
         flush_ack = 1;
         tick();
         flush_ack = 0;
         chk({tag, " req_drop"}, flush_req, 0);
         chk({tag, " busy_drop"}, trap_busy, 0);
         chk({tag, " no_repeat"}, cmt_mstatus_en, 0);
      end
   endtask

   initial begin
      stim_t s;
      exp_t  e;

      // v pc il ec eb lm sm mret bad sw tm ext mstatus mie mtvec mepc
      tbl[0]  = '{'{1, 32'h80000010, 0,1,0,0,0,0, 32'h0,        0,0,0, 32'h28,   32'h0,   32'h80000100, 32'h0},   '{1, 32'd11,       32'h80000010, 32'h0,        32'h18A0, 32'h80000100}};
      tbl[1]  = '{'{1, 32'h80000040, 0,0,0,0,0,0, 32'h0,        0,1,0, 32'h8,    32'h80,  32'h80000101, 32'h0},   '{1, 32'h80000007, 32'h80000040, 32'h0,        32'h1880, 32'h8000011C}};
      tbl[2]  = '{'{1, 32'h80000040, 0,0,0,0,0,0, 32'h0,        0,1,0, 32'h0,    32'h80,  32'h80000101, 32'h0},   '{0, 32'h0,        32'h0,        32'h0,        32'h0,    32'h0}};
      tbl[3]  = '{'{1, 32'h100,      0,0,0,1,0,0, 32'h1003,     0,0,0, 32'h0,    32'h0,   32'h80000100, 32'h0},   '{1, 32'd4,        32'h100,      32'h1003,     32'h1800, 32'h80000100}};
      tbl[4]  = '{'{1, 32'h300,      0,0,0,0,0,1, 32'h0,        0,0,0, 32'h80,   32'h0,   32'h80000100, 32'h200}, '{2, 32'h0,        32'h0,        32'h0,        32'h1888, 32'h200}};
      tbl[5]  = '{'{1, 32'h104,      1,0,1,0,0,1, 32'h55,       0,0,0, 32'h0,    32'h0,   32'h80000101, 32'h200}, '{1, 32'd2,        32'h104,      32'h0,        32'h1800, 32'h80000100}};
      tbl[6]  = '{'{1, 32'h108,      0,0,0,0,1,0, 32'hDEAD0002, 0,0,0, 32'h1808, 32'h0,   32'h80000100, 32'h0},   '{1, 32'd6,        32'h108,      32'hDEAD0002, 32'h1880, 32'h80000100}};
      tbl[7]  = '{'{1, 32'h10C,      0,0,1,0,1,0, 32'h77,       0,0,0, 32'h0,    32'h0,   32'h80000100, 32'h0},   '{1, 32'd3,        32'h10C,      32'h0,        32'h1800, 32'h80000100}};
      tbl[8]  = '{'{0, 32'h110,      0,1,0,0,0,0, 32'h0,        0,0,0, 32'h8,    32'h0,   32'h80000100, 32'h0},   '{0, 32'h0,        32'h0,        32'h0,        32'h0,    32'h0}};
      tbl[9]  = '{'{1, 32'h120,      0,1,0,0,0,0, 32'h0,        1,1,0, 32'h8,    32'h88,  32'h80000200, 32'h0},   '{1, 32'h80000003, 32'h120,      32'h0,        32'h1880, 32'h80000200}};
      tbl[10] = '{'{1, 32'h124,      0,0,0,0,0,0, 32'h0,        1,0,1, 32'h8,    32'h888, 32'h80000001, 32'h0},   '{1, 32'h8000000B, 32'h124,      32'h0,        32'h1880, 32'h8000002C}};
      tbl[11] = '{'{1, 32'h128,      0,0,0,0,0,0, 32'h0,        0,1,0, 32'h8,    32'h8,   32'h80000100, 32'h0},   '{0, 32'h0,        32'h0,        32'h0,        32'h0,    32'h0}};
      tbl[12] = '{'{1, 32'h12C,      0,1,0,0,0,1, 32'h0,        0,0,0, 32'h80,   32'h0,   32'h80000100, 32'h400}, '{1, 32'd11,       32'h12C,      32'h0,        32'h1800, 32'h80000100}};
      tbl[13] = '{'{1, 32'h130,      0,0,0,0,0,0, 32'h0,        0,1,0, 32'h8,    32'h80,  32'h80000002, 32'h0},   '{1, 32'h80000007, 32'h130,      32'h0,        32'h1880, 32'h80000000}};

      rst_n = 0; flush_ack = 0; irq_ext = 0;
      s = tbl[8].s;
      drive(s);
      clear_ex();
      #2;
      chk("reset flush_req", flush_req, 0);
      chk("reset busy", trap_busy, 0);
      chk("reset flush_pc", flush_pc, 0);
      chk("reset strobes", {cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en, cmt_mtval_en}, 0);
      chk("reset data", {cmt_mstatus, cmt_mcause, cmt_mepc, cmt_mtval}, 0);
      #20 rst_n = 1;
      tick();

      foreach (tbl[i]) apply(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i), 0);

      // External irq latency through the synchroniser, no competing exception.
      s = tbl[11].s; s.tm = 0; s.mie = 32'h800; s.pc = 32'h200; s.ext = 0;
      drive(s); irq_ext = 0;
      repeat (NSYNC + 1) tick();
      irq_ext = 1;
      #1 chk("sync busy_c0", trap_busy, 0);
      tick();
      chk("sync busy_c1", trap_busy, 0);
      chk("sync no_commit_c1", cmt_mcause_en, 0);
      tick();
      chk("sync busy_c2", trap_busy, 1);
      tick();
      clear_ex();
      chk("sync mcause", cmt_mcause, 32'h8000000B);
      chk("sync mepc", cmt_mepc, 32'h200);
      flush_ack = 1; tick(); flush_ack = 0;
      irq_ext = 0;
      repeat (NSYNC + 1) tick();

      // irq_ext rises alongside illegal: illegal first, then the still-pending irq.
      ex_valid = 1; excp_illegal = 1; ex_pc = 32'h204; ex_badaddr = 32'h999; irq_ext = 1;
      tick();
      chk("race mcause_illegal", cmt_mcause, 32'd2);
      chk("race mtval", cmt_mtval, 32'h0);
      flush_ack = 1; tick(); flush_ack = 0;
      chk("race busy_idle_irq", trap_busy, 1);
      tick();
      clear_ex();
      chk("race mcause_irq", cmt_mcause, 32'h8000000B);
      chk("race mepc_irq", cmt_mepc, 32'h204);
      flush_ack = 1; tick(); flush_ack = 0;
      irq_ext = 0;
      repeat (NSYNC + 1) tick();

      // Ack withheld while a second ecall waits in EX.
      s = tbl[0].s; s.mstatus = 32'h8;
      drive(s);
      tick();
      chk("hold first_mepc", cmt_mepc, 32'h80000010);
      ex_pc = 32'h80000050; csr_mtvec = 32'h80000300;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold req", flush_req, 1);
         chk("hold pc", flush_pc, 32'h80000100);
         chk("hold busy", trap_busy, 1);
         chk("hold no_commit", {cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en, cmt_mtval_en}, 0);
      end
      flush_ack = 1; tick(); flush_ack = 0;
      chk("hold req_drop", flush_req, 0);
      chk("hold second_detect", trap_busy, 1);
      tick();
      clear_ex();
      chk("hold second_en", cmt_mepc_en, 1);
      chk("hold second_mepc", cmt_mepc, 32'h80000050);
      chk("hold second_pc", flush_pc, 32'h80000300);
      flush_ack = 1; tick(); flush_ack = 0;

      // Reset asserted while a redirect is outstanding.
      s = tbl[3].s;
      drive(s);
      tick();
      clear_ex();
      chk("rst pre_req", flush_req, 1);
      rst_n = 0;
      #1;
      chk("rst req", flush_req, 0);
      chk("rst busy", trap_busy, 0);
      chk("rst pc", flush_pc, 0);
      chk("rst strobes", {cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en, cmt_mtval_en}, 0);
      chk("rst data", {cmt_mstatus, cmt_mcause, cmt_mepc, cmt_mtval}, 0);
      #2 rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst post_strobes", {cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en, cmt_mtval_en}, 0);
         chk("rst post_req", flush_req, 0);
      end

      // Randomized transactions against the reference model.
      for (int n = 0; n < 150; n++) begin
         s.v = ($urandom_range(0, 7) != 0);
         s.pc = $urandom;
         s.il = ($urandom_range(0, 5) == 0); s.ec = ($urandom_range(0, 5) == 0);
         s.eb = ($urandom_range(0, 5) == 0); s.lm = ($urandom_range(0, 4) == 0);
         s.sm = ($urandom_range(0, 4) == 0); s.mret = ($urandom_range(0, 3) == 0);
         s.bad = $urandom;
         s.sw = ($urandom_range(0, 3) == 0); s.tm = ($urandom_range(0, 3) == 0); s.ext = ($urandom_range(0, 3) == 0);
         s.mstatus = $urandom; s.mie = $urandom; s.mepc = $urandom;
         s.mtvec = $urandom; s.mtvec[1:0] = 2'($urandom_range(0, 1));
         e = ref_model(s);
         apply(s, e, $sformatf("rnd%0d", n), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_ex_trap.md
Name: core_ex_trap

Overview:
Next-generation exception/interrupt unit in the EX stage. Arbitrates synchronous exceptions, machine interrupts and MRET, and produces registered CSR commit writes (mstatus/mcause/mepc/mtval). A small FSM holds a flush/redirect request toward the fetch/pipeline control until it is acknowledged. It supports direct and vectored mtvec, synchronises the asynchronous external interrupt, and stalls EX (trap_busy) while a trap is in flight.

Parameters:
XLEN, 32, CSR/data width
PC_WIDTH, 32, PC width
IRQ_SYNC_STAGES, 2, flops in external-irq synchroniser (>=2)
VECTORED_EN, 1, 1 = honour mtvec.MODE=1 for interrupts; 0 = always direct

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  valid instruction in EX this cycle
ex_pc  in  PC_WIDTH  PC of EX instruction
excp_illegal / excp_ecall / excp_ebreak / excp_ld_misalign / excp_st_misalign  in  1 each  sync exception flags, qualified by ex_valid
excp_mret  in  1  MRET in EX
ex_badaddr  in  XLEN  faulting address for misaligned
irq_sw, irq_timer  in  1 each  synchronous pending lines (MSIP, MTIP)
irq_ext  in  1  asynchronous external interrupt (MEIP)
csr_mstatus, csr_mie, csr_mtvec, csr_mepc  in  XLEN each  current CSR values
cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en, cmt_mtval_en  out  1 each  one-cycle CSR write strobes
cmt_mstatus, cmt_mcause, cmt_mepc, cmt_mtval  out  XLEN each  CSR write data
flush_req  out  1  redirect request, held until ack
flush_pc  out  PC_WIDTH  redirect target
flush_ack  in  1  pipeline control accepted redirect
trap_busy  out  1  EX stall while FSM not IDLE

Behaviour:
- Reset: state IDLE; all cmt_* outputs, flush_req, flush_pc, trap_busy, and synchroniser flops = 0.
- irq_ext passes IRQ_SYNC_STAGES flops before use (MEIP latency = IRQ_SYNC_STAGES cycles).
- Evaluation happens only in IDLE with ex_valid=1. Inputs in other states are ignored; trap_busy holds EX.
- Interrupt eligible = csr_mstatus[3] (MIE) & pending & csr_mie bit (11/3/7). Priority is ext(11) > sw(3) > timer(7). mcause = {1'b1, code}.
- Exception priority is illegal(2) > ecall(11) > ebreak(3) > ld_misalign(4) > st_misalign(6). mcause MSB = 0.
- Interrupt beats exception and MRET in the same cycle. Exception beats MRET.
- Trap taken in cycle N, registered in cycle N+1:
  - Strobe cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en for one cycle. mepc = ex_pc (zero-extended).
  - mstatus update: MPIE(bit7) <= MIE, MIE <= 0, MPP[12:11] <= 2'b11, other bits unchanged.
  - cmt_mtval_en = 1. mtval = ex_badaddr for misaligned, 0 for all other causes.
  - flush_pc = mtvec base ({mtvec[XLEN-1:2],2'b00}). When VECTORED_EN & mtvec[1:0]==1 & interrupt, flush_pc = base + 4*code.
  - flush_req = 1, state -> FLUSH.
- MRET in cycle N, registered in cycle N+1:
  - cmt_mstatus_en only. MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
  - flush_pc = csr_mepc, flush_req = 1, state -> FLUSH.
- FLUSH state: flush_req and flush_pc held stable, trap_busy = 1. On flush_ack: next cycle flush_req = 0, state -> IDLE.
- An ack coincident with the first flush_req cycle is valid, giving a 1-cycle request.
- Commit strobes never repeat while in FLUSH.
- trap_busy = (state != IDLE). It is also asserted combinationally in cycle N when a trap/MRET is detected, so EX does not advance past it.
- Async reset mid-FLUSH: everything returns to reset values immediately and no commit is issued.
- A pending interrupt that is still asserted after the FSM returns to IDLE is taken on the next ex_valid.

Decomposition:
- Cause codes (2,3,4,6,11; irq 3,7,11), mstatus bit positions (MIE=3, MPIE=7, MPP=12:11), and FSM state encodings go in core_defines.v as shared defines.
- One sub-module: core_irq_sync, a parametrised N-flop synchroniser with async active-low reset, instantiated for irq_ext.

Test Plan:
1. ecall, ex_valid=1, ex_pc=0x80000010, mtvec=0x80000100 -> next cycle: mcause=11, mepc=0x80000010, MIE cleared, MPIE=old MIE, flush_req=1, flush_pc=0x80000100. Held until flush_ack, then IDLE.
2. irq_timer=1, mie[7]=1, MIE=1, mtvec=0x80000101, ex_pc=0x80000040 -> mcause=0x80000007, flush_pc=0x8000011C, mepc=0x80000040. Same with MIE=0 -> no trap.
3. irq_ext rising while excp_illegal asserted, after 2-cycle sync -> interrupt wins: mcause=0x8000000B. Before sync completes -> illegal wins: mcause=2, mtval=0.
4. excp_ld_misalign with ex_badaddr=0x1003 -> mcause=4, mtval=0x1003. Then mret with mepc=0x200 and MPIE=1 -> only cmt_mstatus_en asserted, MIE=1, flush_pc=0x200.
5. flush_ack withheld 5 cycles with a new ecall presented meanwhile -> flush_req/flush_pc stable, trap_busy=1, no second commit. Second ecall taken only after return to IDLE.
6. rst_n dropped during FLUSH -> flush_req, trap_busy, and all cmt_* go to 0 immediately. After release, state is IDLE with no spurious strobe.
